mem_arbiter: RTL and testbench

Arbitrates the CPU's single external memory bus between the instruction-fetch port and the data (MEM-stage) port. Only one bus transaction is outstanding at a time. The block produces per-port stall requests for the pipeline controller, which uses them alongside the ID-stage load-use stall. Read data is registered and returned with a one-cycle done pulse. A flush suppresses delivery of an in-flight fetch without aborting the bus cycle.

---
 rtl/mem_arbiter_if.sv | 39 +++
 rtl/mem_arbiter.sv | 82 ++++++++
 tb/tb_mem_arbiter.sv | 218 +++++++++++++++++++++
 3 files changed

// File: rtl/mem_arbiter_if.sv
// Signal bundle between mem_arbiter, its two pipeline ports and the external memory bus.
// slave is the arbiter's view; master is the view of whoever drives the ports and the bus.
interface mem_arbiter_if;
  logic        if_req;
  logic [31:0] if_addr;
  logic [31:0] if_rdata;
  logic        if_done;
  logic        mem_req;
  logic        mem_we;
  logic [3:0]  mem_sel;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;
  logic        mem_done;
  logic        flush;
  logic        bus_stb;
  logic        bus_we;
  logic [3:0]  bus_sel;
  logic [31:0] bus_addr;
  logic [31:0] bus_wdata;
  logic [31:0] bus_rdata;
  logic        bus_ack;
  logic        stallreq_if;
  logic        stallreq_mem;

  modport slave (
    input  if_req, if_addr, mem_req, mem_we, mem_sel, mem_addr, mem_wdata, flush,
           bus_rdata, bus_ack,
    output if_rdata, if_done, mem_rdata, mem_done, bus_stb, bus_we, bus_sel, bus_addr,
           bus_wdata, stallreq_if, stallreq_mem
  );

  modport master (
    output if_req, if_addr, mem_req, mem_we, mem_sel, mem_addr, mem_wdata, flush,
           bus_rdata, bus_ack,
    input  if_rdata, if_done, mem_rdata, mem_done, bus_stb, bus_we, bus_sel, bus_addr,
           bus_wdata, stallreq_if, stallreq_mem
  );
endinterface

// File: rtl/mem_arbiter.sv
// Shares one memory bus between fetch and data ports, one transaction at a time; min 3 cycles req->done.
// No backpressure beyond the bus: a port stalls (stallreq_*) until its done pulse; losing port waits one transaction.
module mem_arbiter (
  input  logic         clk,
  input  logic         rst_n,
  mem_arbiter_if.slave arb
);
  typedef enum logic [1:0] {IDLE, BUS_IF, BUS_MEM, RESP} state_t;

  state_t state, state_nxt;
  logic   owner_mem;
  logic   last_mem;
  logic   drop;
  logic   grant_mem;
  logic   grant_if;

  // Contention alternates: MEM wins unless it won the previous grant.
  assign grant_mem = arb.mem_req & (~arb.if_req | ~last_mem);
  assign grant_if  = arb.if_req & ~grant_mem;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (grant_mem)     state_nxt = BUS_MEM;
        else if (grant_if) state_nxt = BUS_IF;
      end
      BUS_IF, BUS_MEM: begin
        if (arb.bus_ack) state_nxt = RESP;
      end
      RESP:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      owner_mem     <= 1'b0;
      last_mem      <= 1'b0;
      drop          <= 1'b0;
      arb.bus_we    <= 1'b0;
      arb.bus_sel   <= 4'h0;
      arb.bus_addr  <= 32'h0;
      arb.bus_wdata <= 32'h0;
      arb.if_rdata  <= 32'h0;
      arb.mem_rdata <= 32'h0;
    end else begin
      if (state == IDLE && (grant_if || grant_mem)) begin
        owner_mem     <= grant_mem;
        last_mem      <= grant_mem;
        arb.bus_we    <= grant_mem & arb.mem_we;
        arb.bus_sel   <= grant_mem ? arb.mem_sel   : 4'hF;
        arb.bus_addr  <= grant_mem ? arb.mem_addr  : arb.if_addr;
        arb.bus_wdata <= grant_mem ? arb.mem_wdata : 32'h0;
      end

      // A killed fetch still runs to completion on the bus; only its done pulse is dropped.
      case (state)
        IDLE:    drop <= grant_if & arb.flush;
        BUS_IF:  if (arb.flush) drop <= 1'b1;
        RESP:    drop <= 1'b0;
        default: drop <= drop;
      endcase

      if (arb.bus_ack && state == BUS_IF)
        arb.if_rdata <= arb.bus_rdata;
      if (arb.bus_ack && state == BUS_MEM && !arb.bus_we)
        arb.mem_rdata <= arb.bus_rdata;
    end
  end

  assign arb.bus_stb      = (state == BUS_IF) || (state == BUS_MEM);
  assign arb.if_done      = (state == RESP) & ~owner_mem & ~drop & ~arb.flush;
  assign arb.mem_done     = (state == RESP) & owner_mem;
  assign arb.stallreq_if  = arb.if_req & ~arb.if_done;
  assign arb.stallreq_mem = arb.mem_req & ~arb.mem_done;
endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: fetch, slow load, contention, store, flush and reset-abort scenarios.
module tb_mem_arbiter;
  logic clk;
  logic rst_n;
  int   n_checks;
  int   n_errors;
  int   stall_cnt;
  int   bad;

  mem_arbiter_if arb ();

  mem_arbiter dut (
    .clk   (clk),
    .rst_n (rst_n),
    .arb   (arb.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %08h expected %08h", tag, got, exp);
    end
  endtask

  task automatic wait_stb(input string tag);
    int n = 0;
    while (arb.bus_stb !== 1'b1 && n < 20) begin
      @(negedge clk);
      n++;
    end
    check(tag, 32'(arb.bus_stb), 32'd1);
  endtask

  // Called in the first strobe cycle; ack is sampled at the cycles-th strobe edge.
  task automatic ack_after(input int cycles, input logic [31:0] d);
    repeat (cycles - 1) @(negedge clk);
    arb.bus_ack   = 1'b1;
    arb.bus_rdata = d;
    @(negedge clk);
    arb.bus_ack   = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    n_checks = 0;
    n_errors = 0;
    rst_n = 1'b0;
    arb.if_req = 1'b0;   arb.if_addr = 32'h0;
    arb.mem_req = 1'b0;  arb.mem_we = 1'b0; arb.mem_sel = 4'h0;
    arb.mem_addr = 32'h0; arb.mem_wdata = 32'h0;
    arb.flush = 1'b0;    arb.bus_ack = 1'b0; arb.bus_rdata = 32'h0;

    repeat (2) @(negedge clk);
    check("rst_stb",   32'(arb.bus_stb),  32'd0);
    check("rst_ifd",   32'(arb.if_done),  32'd0);
    check("rst_memd",  32'(arb.mem_done), 32'd0);
    check("rst_addr",  arb.bus_addr,      32'h0);
    check("rst_ifrd",  arb.if_rdata,      32'h0);
    rst_n = 1'b1;
    @(negedge clk);

    // Single fetch, ack in the second strobe cycle
    arb.if_req = 1'b1; arb.if_addr = 32'h100;
    @(negedge clk);
    wait_stb("f_stb");
    check("f_addr",  arb.bus_addr,        32'h100);
    check("f_sel",   32'(arb.bus_sel),    32'hF);
    check("f_we",    32'(arb.bus_we),     32'd0);
    check("f_wdata", arb.bus_wdata,       32'h0);
    ack_after(2, 32'h34020001);
    check("f_done",  32'(arb.if_done),    32'd1);
    check("f_rdata", arb.if_rdata,        32'h34020001);
    check("f_stall", 32'(arb.stallreq_if), 32'd0);
    arb.if_req = 1'b0;
    @(negedge clk);
    check("f_once",  32'(arb.if_done),    32'd0);

    // Slow load: ack at the 10th strobe edge
    arb.mem_req = 1'b1; arb.mem_we = 1'b0; arb.mem_sel = 4'hF;
    arb.mem_addr = 32'h500; arb.mem_wdata = 32'h0;
    stall_cnt = 0;
    bad = 0;
    for (int i = 0; i < 11; i++) begin
      #1;
      if (arb.stallreq_mem === 1'b1) stall_cnt++;
      if (i > 0 && (arb.bus_stb !== 1'b1 || arb.bus_addr !== 32'h500 ||
                    arb.bus_we !== 1'b0 || arb.bus_sel !== 4'hF)) bad++;
      if (i == 10) begin
        arb.bus_ack = 1'b1; arb.bus_rdata = 32'h12345678;
      end
      @(negedge clk);
      arb.bus_ack = 1'b0;
    end
    check("s_stallcnt", 32'(stall_cnt), 32'd11);
    check("s_stable",   32'(bad),       32'd0);
    check("s_done",     32'(arb.mem_done),     32'd1);
    check("s_stall",    32'(arb.stallreq_mem), 32'd0);
    check("s_rdata",    arb.mem_rdata,         32'h12345678);
    arb.mem_req = 1'b0;
    @(negedge clk);

    // Contention after a MEM grant: IF, then MEM, then IF again
    arb.if_req = 1'b1;  arb.if_addr = 32'h300;
    arb.mem_req = 1'b1; arb.mem_we = 1'b0; arb.mem_addr = 32'h200;
    @(negedge clk);
    wait_stb("c1_stb");
    check("c1_addr",  arb.bus_addr,             32'h300);
    check("c1_mstall", 32'(arb.stallreq_mem),   32'd1);
    ack_after(1, 32'hA0A0A0A0);
    check("c1_ifd",   32'(arb.if_done),         32'd1);
    check("c1_memd",  32'(arb.mem_done),        32'd0);
    check("c1_mstall2", 32'(arb.stallreq_mem),  32'd1);
    arb.if_addr = 32'h304;
    @(negedge clk);
    check("c2_idle",  32'(arb.bus_stb),         32'd0);
    @(negedge clk);
    wait_stb("c2_stb");
    check("c2_addr",  arb.bus_addr,             32'h200);
    check("c2_istall", 32'(arb.stallreq_if),    32'd1);
    ack_after(1, 32'hB0B0B0B0);
    check("c2_memd",  32'(arb.mem_done),        32'd1);
    check("c2_rdata", arb.mem_rdata,            32'hB0B0B0B0);
    check("c2_istall2", 32'(arb.stallreq_if),   32'd1);
    arb.mem_req = 1'b0;
    @(negedge clk);
    @(negedge clk);
    wait_stb("c3_stb");
    check("c3_addr",  arb.bus_addr,             32'h304);
    ack_after(1, 32'hC0C0C0C0);
    check("c3_ifd",   32'(arb.if_done),         32'd1);
    check("c3_rdata", arb.if_rdata,             32'hC0C0C0C0);
    arb.if_req = 1'b0;
    @(negedge clk);

    // Store: read data on the bus must not reach mem_rdata
    arb.mem_req = 1'b1; arb.mem_we = 1'b1; arb.mem_sel = 4'b0011;
    arb.mem_addr = 32'h400; arb.mem_wdata = 32'hAABBCCDD;
    @(negedge clk);
    wait_stb("st_stb");
    check("st_we",    32'(arb.bus_we),  32'd1);
    check("st_sel",   32'(arb.bus_sel), 32'h3);
    check("st_addr",  arb.bus_addr,     32'h400);
    check("st_wdata", arb.bus_wdata,    32'hAABBCCDD);
    ack_after(1, 32'hDEADBEEF);
    check("st_done",  32'(arb.mem_done), 32'd1);
    check("st_rdata", arb.mem_rdata,    32'hB0B0B0B0);
    arb.mem_req = 1'b0; arb.mem_we = 1'b0;
    @(negedge clk);

    // Flush in the second BUS_IF cycle
    arb.if_req = 1'b1; arb.if_addr = 32'h600;
    @(negedge clk);
    wait_stb("fl_stb");
    @(negedge clk);
    arb.flush = 1'b1;
    @(negedge clk);
    arb.flush = 1'b0;
    check("fl_hold",  32'(arb.bus_stb), 32'd1);
    arb.bus_ack = 1'b1; arb.bus_rdata = 32'h11111111;
    @(negedge clk);
    arb.bus_ack = 1'b0;
    check("fl_nodone", 32'(arb.if_done), 32'd0);
    arb.if_req = 1'b0;
    @(negedge clk);
    check("fl_idle",  32'(arb.bus_stb), 32'd0);
    check("fl_nodone2", 32'(arb.if_done), 32'd0);
    arb.if_req = 1'b1; arb.if_addr = 32'h604;
    @(negedge clk);
    wait_stb("fl2_stb");
    check("fl2_addr", arb.bus_addr, 32'h604);
    ack_after(1, 32'h22222222);
    check("fl2_done", 32'(arb.if_done), 32'd1);
    check("fl2_rdata", arb.if_rdata,    32'h22222222);
    arb.if_req = 1'b0;
    @(negedge clk);

    // Reset during BUS_MEM, then a stray ack
    arb.mem_req = 1'b1; arb.mem_we = 1'b0; arb.mem_sel = 4'hF; arb.mem_addr = 32'h700;
    @(negedge clk);
    wait_stb("r_stb");
    rst_n = 1'b0;
    #1;
    check("r_stb0",   32'(arb.bus_stb),  32'd0);
    check("r_addr0",  arb.bus_addr,      32'h0);
    check("r_sel0",   32'(arb.bus_sel),  32'h0);
    check("r_ifrd0",  arb.if_rdata,      32'h0);
    check("r_memrd0", arb.mem_rdata,     32'h0);
    arb.mem_req = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    arb.bus_ack = 1'b1; arb.bus_rdata = 32'h99999999;
    @(negedge clk);
    arb.bus_ack = 1'b0;
    check("r_stray_stb",  32'(arb.bus_stb),  32'd0);
    check("r_stray_done", 32'(arb.mem_done), 32'd0);
    check("r_stray_rd",   arb.mem_rdata,     32'h0);
    arb.if_req = 1'b1; arb.if_addr = 32'h800;
    @(negedge clk);
    check("r_idle_grant", 32'(arb.bus_stb), 32'd1);
    check("r_idle_addr",  arb.bus_addr,     32'h800);
    ack_after(1, 32'h33333333);
    check("r_ifdone",     32'(arb.if_done), 32'd1);
    arb.if_req = 1'b0;
    @(negedge clk);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
